dual_key_led_ctrl: RTL and testbench

Controller that sequences the team's single LED output from two raw push-button inputs (key1, key2).
- Synchronises and debounces each key, then produces one-cycle press flags.
- Runs a 4-state mode FSM: off, two blink rates, and an AND mode where the LED is steady on while both keys are held.
- Sits between the board buttons and the LED pin, replacing the direct combinational key-to-LED path.

---
 rtl/dual_key_led_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dual_key_led_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dual_key_led_ctrl.sv
// Two-key debounced LED mode controller: IDLE, BLINK1, BLINK2, AND_ON.
// Define AUTO_OFF_EN to return blink modes to IDLE after 32 LED toggles.
module dual_key_led_ctrl #(
  parameter int CNT_MAX    = 1000000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  output logic       led,
  output logic [1:0] mode,
  output logic       key1_flag,
  output logic       key2_flag
);

  localparam int CW = $clog2(CNT_MAX);
  localparam int BW = $clog2(2 * BLINK_HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [BW-1:0] B1_LAST  = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] B2_LAST  = BW'(2 * BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_BLINK1 = 2'b01,
    S_BLINK2 = 2'b10,
    S_AND    = 2'b11
  } state_t;

  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_db;
  logic [1:0]    r_flag;
  logic [CW-1:0] r_dcnt [2];

  state_t        r_state;
  state_t        w_state;
  logic          r_led;
  logic          w_led;
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt;
  logic [BW-1:0] w_half_last;
  logic          w_blink;
  logic          w_wrap;

  // bit 0 is key1, bit 1 is key2 throughout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_flag <= '0;
      for (int i = 0; i < 2; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_s1   <= {key2, key1};
      r_s2   <= r_s1;
      r_flag <= '0;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == CNT_LAST) begin
          r_db[i]   <= r_s2[i];
          r_flag[i] <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef AUTO_OFF_EN
  logic [4:0] r_tog;
  logic [4:0] w_tog;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_led   <= 1'b0;
      r_bcnt  <= '0;
`ifdef AUTO_OFF_EN
      r_tog   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_led   <= w_led;
      r_bcnt  <= w_bcnt;
`ifdef AUTO_OFF_EN
      r_tog   <= w_tog;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_led       = r_led;
    w_bcnt      = r_bcnt;
    w_blink     = (r_state == S_BLINK1) || (r_state == S_BLINK2);
    w_half_last = (r_state == S_BLINK2) ? B2_LAST : B1_LAST;
    w_wrap      = (r_bcnt == w_half_last);
`ifdef AUTO_OFF_EN
    w_tog       = r_tog;
`endif

    if (&r_db) begin
      w_state = S_AND;
    end else begin
      unique case (r_state)
        S_AND: w_state = S_IDLE;
        S_IDLE: begin
          if (r_flag[0])      w_state = S_BLINK1;
          else if (r_flag[1]) w_state = S_BLINK2;
        end
        S_BLINK1: begin
          if (r_flag[0])      w_state = S_IDLE;
          else if (r_flag[1]) w_state = S_BLINK2;
        end
        S_BLINK2: begin
          if (r_flag[1])      w_state = S_IDLE;
          else if (r_flag[0]) w_state = S_BLINK1;
        end
        default: w_state = S_IDLE;
      endcase
`ifdef AUTO_OFF_EN
      if (w_blink && w_wrap && (r_tog == 5'd31)) begin
        w_state = S_IDLE;
      end
`endif
    end

    unique case (w_state)
      S_IDLE: begin
        w_led  = 1'b0;
        w_bcnt = '0;
      end
      S_AND: begin
        w_led  = 1'b1;
        w_bcnt = '0;
      end
      default: begin
        // entering or switching blink rate restarts the phase
        if (w_state != r_state) begin
          w_led  = 1'b1;
          w_bcnt = '0;
        end else if (w_wrap) begin
          w_led  = ~r_led;
          w_bcnt = '0;
        end else begin
          w_bcnt = r_bcnt + BW'(1);
        end
      end
    endcase

`ifdef AUTO_OFF_EN
    if (w_state != r_state) begin
      w_tog = '0;
    end else if (w_blink && w_wrap) begin
      w_tog = r_tog + 5'd1;
    end
`endif
  end

  assign led       = r_led;
  assign mode      = r_state;
  assign key1_flag = r_flag[0];
  assign key2_flag = r_flag[1];

endmodule

// File: tb/tb_dual_key_led_ctrl.sv
// Scoreboard bench for dual_key_led_ctrl: a timeline-based reference model
// pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_dual_key_led_ctrl;

  localparam int CM = 4;
  localparam int BH = 3;

  bit          clk;
  logic        rst  = 1'b1;
  logic        key1 = 1'b0;
  logic        key2 = 1'b0;
  logic        led;
  logic [1:0]  mode;
  logic        key1_flag;
  logic        key2_flag;

  always #5 clk = ~clk;

  dual_key_led_ctrl #(
    .CNT_MAX    (CM),
    .BLINK_HALF (BH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key1      (key1),
    .key2      (key2),
    .led       (led),
    .mode      (mode),
    .key1_flag (key1_flag),
    .key2_flag (key2_flag)
  );

  typedef struct packed {
    logic       led;
    logic [1:0] mode;
    logic       f1;
    logic       f2;
  } exp_t;

  exp_t       q[$];
  int         checks  = 0;
  int         errors  = 0;
  int         cyc     = 0;
  bit         started = 0;

  // reference model state
  int         m_mode = 0;
  int         m_k    = 0;
  bit         m_led  = 0;
  bit         m_db [2];
  bit         m_fl [2];
  int         m_run [2];
  logic [1:0] hist[$];

  initial begin
    hist.push_back(2'b00);
    hist.push_back(2'b00);
  end

  always @(posedge clk) begin
    logic [1:0] syn;
    int         nm;
    exp_t       e;
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_k    = 0;
      m_led  = 0;
      hist.delete();
      hist.push_back(2'b00);
      hist.push_back(2'b00);
      for (int i = 0; i < 2; i++) begin
        m_db[i]  = 0;
        m_fl[i]  = 0;
        m_run[i] = 0;
      end
    end else begin
      syn = hist.pop_front();
      hist.push_back({key2, key1});
      nm = m_mode;
      if (m_db[0] && m_db[1]) nm = 3;
      else if (m_mode == 3) nm = 0;
      else begin
        if (m_mode == 0) begin
          if (m_fl[0]) nm = 1;
          else if (m_fl[1]) nm = 2;
        end else if (m_mode == 1) begin
          if (m_fl[0]) nm = 0;
          else if (m_fl[1]) nm = 2;
        end else begin
          if (m_fl[1]) nm = 0;
          else if (m_fl[0]) nm = 1;
        end
`ifdef AUTO_OFF_EN
        if ((m_mode == 1 || m_mode == 2) &&
            (m_k + 1 == 32 * BH * m_mode)) nm = 0;
`endif
      end
      m_k    = (nm != m_mode) ? 0 : m_k + 1;
      m_mode = nm;
      if (nm == 0) m_led = 0;
      else if (nm == 3) m_led = 1;
      else m_led = ((m_k / (BH * nm)) % 2) == 0;
      for (int i = 0; i < 2; i++) begin
        m_fl[i] = 0;
        if (syn[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == CM) begin
            m_db[i]  = syn[i];
            m_fl[i]  = syn[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    e.led  = m_led;
    e.mode = 2'(m_mode);
    e.f1   = m_fl[0];
    e.f2   = m_fl[1];
    q.push_back(e);
    started = 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty cyc=%0d no expectation queued", cyc);
      end else begin
        e = q.pop_front();
        if ({led, mode, key1_flag, key2_flag} !== e) begin
          errors++;
          $display("FAIL out cyc=%0d got led=%b mode=%b f1=%b f2=%b exp led=%b mode=%b f1=%b f2=%b",
                   cyc, led, mode, key1_flag, key2_flag,
                   e.led, e.mode, e.f1, e.f2);
        end
      end
    end
  end

  task automatic drive(input bit a, input bit b, input bit r, input int n);
    repeat (n) begin
      key1 = a;
      key2 = b;
      rst  = r;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    bit r;
    drive(1, 1, 1, 3);
    drive(1, 1, 0, 12);
    drive(0, 0, 0, 10);
    drive(1, 0, 0, 3);
    drive(0, 0, 0, 10);
    drive(1, 0, 0, 20);
    drive(0, 0, 0, 20);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 30);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 15);
    drive(1, 1, 0, 15);
    drive(1, 0, 0, 15);
    drive(0, 0, 0, 10);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 5);
    drive(1, 0, 0, 2);
    drive(1, 0, 1, 1);
    drive(0, 0, 0, 20);
    drive(1, 0, 0, 10);
    drive(0, 0, 0, 120);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 210);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 60) == 0);
      n = r ? 1 : $urandom_range(1, 20);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, n);
    end
    drive(0, 0, 0, 10);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
